// File: rtl/sha256_stream_pkg.sv
// Shared constants for the SHA-256 streaming front-end: core register map, CTRL bits, FSM states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package sha256_stream_pkg;

    localparam logic [7:0] ADDR_CTRL   = 8'h08;
    localparam logic [7:0] ADDR_STATUS = 8'h09;
    localparam logic [7:0] ADDR_BLOCK  = 8'h10;
    localparam logic [7:0] ADDR_DIGEST = 8'h20;

    localparam int CTRL_INIT_BIT    = 0;
    localparam int CTRL_NEXT_BIT    = 1;
    localparam int CTRL_MODE_BIT    = 2;
    localparam int STATUS_READY_BIT = 0;

    localparam logic [7:0] PAD_BYTE = 8'h80;

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_FILL      = 4'd1;
    localparam logic [3:0] ST_WRITE_BLK = 4'd2;
    localparam logic [3:0] ST_START     = 4'd3;
    localparam logic [3:0] ST_POLL      = 4'd4;
    localparam logic [3:0] ST_PAD_FILL  = 4'd5;
    localparam logic [3:0] ST_READ_DIG  = 4'd6;
    localparam logic [3:0] ST_DONE      = 4'd7;

    // One-cycle padding request: optionally place 0x80 at ptr, zero everything after it,
    // and optionally overwrite bytes 56..63 with the 64-bit message bit length.
    typedef struct packed {
        logic       en;
        logic       mark;
        logic       len_en;
        logic [5:0] ptr;
    } pad_cmd_t;

endpackage

// File: rtl/sha256_block_buffer.sv
// 64-byte block buffer: big-endian beat packing, 0x80/zero/length padding, word read port.
// Latency: writes land on the next clock; the read port is combinational.
// Backpressure: none; the FSM owns all sequencing.
module sha256_block_buffer
    import sha256_stream_pkg::*;
#(
    parameter int BYTES_PER_BEAT = 4
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        wr_en,
    input  logic [5:0]                  wr_ptr,
    input  logic [8*BYTES_PER_BEAT-1:0] wr_data,
    input  logic [2:0]                  wr_nbytes,
    input  pad_cmd_t                    pad,
    input  logic [63:0]                 bit_len,
    input  logic [3:0]                  rd_idx,
    output logic [31:0]                 rd_word
);

    logic [7:0] byte_q [64];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int j = 0; j < 64; j++) byte_q[j] <= '0;
        end else begin
            if (wr_en) begin
                for (int k = 0; k < BYTES_PER_BEAT; k++) begin
                    if (3'(k) < wr_nbytes)
                        byte_q[wr_ptr + 6'(k)] <= wr_data[8*(BYTES_PER_BEAT-1-k) +: 8];
                end
            end
            if (pad.en) begin
                for (int j = 0; j < 64; j++) begin
                    if (6'(j) >= pad.ptr)
                        byte_q[j] <= (pad.mark && 6'(j) == pad.ptr) ? PAD_BYTE : 8'h00;
                    // Length wins over the zero fill in the tail of the block.
                    if (pad.len_en && j >= 56)
                        byte_q[j] <= bit_len[8*(63-j) +: 8];
                end
            end
        end
    end

    assign rd_word = {byte_q[{rd_idx, 2'd0}], byte_q[{rd_idx, 2'd1}],
                      byte_q[{rd_idx, 2'd2}], byte_q[{rd_idx, 2'd3}]};

endmodule

// File: rtl/sha256_stream_hasher.sv
// Streams a byte message into the sha256 core over its register bus and returns the digest.
// Latency: per block 16 writes + 1 CTRL write + status polls; digest 8 reads + 1 cycle.
// Backpressure: s_ready only in IDLE/FILL; core completion absorbed by polling with a timeout.
module sha256_stream_hasher
    import sha256_stream_pkg::*;
#(
    parameter int   BYTES_PER_BEAT = 4,
    parameter int   LEN_W          = 32,
    parameter int   POLL_LIMIT     = 1023,
    parameter logic MODE_SHA256    = 1'b1
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic                        s_valid,
    output logic                        s_ready,
    input  logic [8*BYTES_PER_BEAT-1:0] s_data,
    input  logic                        s_last,
    input  logic [2:0]                  s_nbytes,
    output logic                        m_cs,
    output logic                        m_we,
    output logic [7:0]                  m_address,
    output logic [31:0]                 m_write_data,
    input  logic [31:0]                 m_read_data,
    input  logic                        m_error,
    output logic [255:0]                digest,
    output logic                        digest_valid,
    output logic                        busy,
    output logic                        error
);

    localparam int PW = (POLL_LIMIT < 1) ? 1 : $clog2(POLL_LIMIT + 1);

    logic [3:0]       state_q;
    logic             ready_en_q;
    logic [LEN_W-1:0] byte_cnt_q;
    logic [3:0]       widx_q;
    logic [PW-1:0]    poll_cnt_q;
    logic             first_blk_q, last_seen_q, mark_pending_q, len_done_q, drop_q, error_q;
    logic [255:0]     digest_q;

    logic             beat_acc, first_beat, data_beat, blk_full, overflow, poll_timeout, abort;
    logic [2:0]       beat_bytes;
    logic [LEN_W-1:0] base_cnt;
    logic [LEN_W:0]   sum;
    logic [31:0]      rd_word;
    pad_cmd_t         pad;

    assign s_ready    = ready_en_q && (state_q == ST_IDLE || state_q == ST_FILL);
    assign beat_acc   = s_valid && s_ready;
    // While dropping an aborted message, beats are consumed until its s_last.
    assign data_beat  = beat_acc && !(state_q == ST_IDLE && drop_q);
    assign first_beat = data_beat && state_q == ST_IDLE;

    always_comb begin
        beat_bytes = 3'(BYTES_PER_BEAT);
        if (s_last)
            beat_bytes = (s_nbytes > 3'(BYTES_PER_BEAT)) ? 3'(BYTES_PER_BEAT) : s_nbytes;
    end

    assign base_cnt = (state_q == ST_IDLE) ? '0 : byte_cnt_q;
    assign sum      = {1'b0, base_cnt} + {{(LEN_W-2){1'b0}}, beat_bytes};
    assign overflow = sum[LEN_W];
    assign blk_full = ({1'b0, base_cnt[5:0]} + {4'b0, beat_bytes}) == 7'd64;

    assign poll_timeout = state_q == ST_POLL && !m_read_data[STATUS_READY_BIT]
                          && poll_cnt_q == PW'(POLL_LIMIT);
    assign abort = (m_cs && m_error) || (data_beat && overflow) || poll_timeout;

    assign pad.en     = state_q == ST_PAD_FILL;
    assign pad.mark   = mark_pending_q;
    assign pad.ptr    = mark_pending_q ? byte_cnt_q[5:0] : 6'd0;
    assign pad.len_en = !mark_pending_q || byte_cnt_q[5:0] < 6'd56;

    sha256_block_buffer #(.BYTES_PER_BEAT(BYTES_PER_BEAT)) u_buf (
        .clk       (clk),
        .reset_n   (reset_n),
        .wr_en     (data_beat && !overflow),
        .wr_ptr    (base_cnt[5:0]),
        .wr_data   (s_data),
        .wr_nbytes (beat_bytes),
        .pad       (pad),
        .bit_len   (64'({byte_cnt_q, 3'b000})),
        .rd_idx    (widx_q),
        .rd_word   (rd_word)
    );

    always_comb begin
        m_cs         = 1'b0;
        m_we         = 1'b0;
        m_address    = 8'h00;
        m_write_data = 32'h0;
        case (state_q)
            ST_WRITE_BLK: begin
                m_cs         = 1'b1;
                m_we         = 1'b1;
                m_address    = ADDR_BLOCK + {4'b0, widx_q};
                m_write_data = rd_word;
            end
            ST_START: begin
                m_cs      = 1'b1;
                m_we      = 1'b1;
                m_address = ADDR_CTRL;
                m_write_data[CTRL_MODE_BIT] = MODE_SHA256;
                m_write_data[CTRL_NEXT_BIT] = !first_blk_q;
                m_write_data[CTRL_INIT_BIT] = first_blk_q;
            end
            ST_POLL: begin
                m_cs      = 1'b1;
                m_address = ADDR_STATUS;
            end
            ST_READ_DIG: begin
                m_cs      = 1'b1;
                m_address = ADDR_DIGEST + {5'b0, widx_q[2:0]};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            ready_en_q     <= 1'b0;
            byte_cnt_q     <= '0;
            widx_q         <= '0;
            poll_cnt_q     <= '0;
            first_blk_q    <= 1'b0;
            last_seen_q    <= 1'b0;
            mark_pending_q <= 1'b0;
            len_done_q     <= 1'b0;
            drop_q         <= 1'b0;
            error_q        <= 1'b0;
            digest_q       <= '0;
        end else begin
            ready_en_q <= 1'b1;
            if (abort) begin
                state_q <= ST_IDLE;
                error_q <= 1'b1;
                drop_q  <= data_beat ? !s_last : !last_seen_q;
            end else begin
                case (state_q)
                    ST_IDLE, ST_FILL: begin
                        if (data_beat) begin
                            if (first_beat) begin
                                error_q        <= 1'b0;
                                first_blk_q    <= 1'b1;
                                mark_pending_q <= 1'b1;
                                len_done_q     <= 1'b0;
                            end
                            last_seen_q <= s_last;
                            byte_cnt_q  <= sum[LEN_W-1:0];
                            widx_q      <= '0;
                            if (blk_full)    state_q <= ST_WRITE_BLK;
                            else if (s_last) state_q <= ST_PAD_FILL;
                            else             state_q <= ST_FILL;
                        end else if (beat_acc && s_last) begin
                            drop_q <= 1'b0;
                        end
                    end
                    ST_WRITE_BLK: begin
                        widx_q <= widx_q + 4'd1;
                        if (widx_q == 4'd15) state_q <= ST_START;
                    end
                    ST_START: begin
                        first_blk_q <= 1'b0;
                        poll_cnt_q  <= '0;
                        state_q     <= ST_POLL;
                    end
                    ST_POLL: begin
                        if (m_read_data[STATUS_READY_BIT]) begin
                            widx_q <= '0;
                            if (!last_seen_q)     state_q <= ST_FILL;
                            else if (!len_done_q) state_q <= ST_PAD_FILL;
                            else                  state_q <= ST_READ_DIG;
                        end else begin
                            poll_cnt_q <= poll_cnt_q + 1'b1;
                        end
                    end
                    ST_PAD_FILL: begin
                        mark_pending_q <= 1'b0;
                        if (pad.len_en) len_done_q <= 1'b1;
                        widx_q  <= '0;
                        state_q <= ST_WRITE_BLK;
                    end
                    ST_READ_DIG: begin
                        digest_q[{~widx_q[2:0], 5'b0} +: 32] <= m_read_data;
                        widx_q <= widx_q + 4'd1;
                        if (widx_q[2:0] == 3'd7) state_q <= ST_DONE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign digest       = digest_q;
    assign digest_valid = state_q == ST_DONE;
    assign busy         = !(state_q == ST_IDLE || state_q == ST_DONE);
    assign error        = error_q;

endmodule

// File: doc/sha256_stream_hasher.md
Name: sha256_stream_hasher

Overview:
- Streaming front-end that turns an arbitrary-length byte message into SHA-256 digests by driving the existing sha256 core over its cs/we/address register bus.
- Performs FIPS 180-4 padding and length append, sequences init/next block starts, polls for completion and returns the 256-bit digest.
- Sits between the vote-record packer and the sha256 core, so software no longer hand-writes blocks and control words.

Parameters:
BYTES_PER_BEAT, 4, input beat width in bytes; legal values 1 or 4.
LEN_W, 32, message byte-counter width; maximum message length is 2^LEN_W-1 bytes.
POLL_LIMIT, 1023, status reads allowed per block before a timeout error.
MODE_SHA256, 1, value driven into CTRL bit2 (1 = SHA-256, 0 = SHA-224).

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&&s_ready
s_data  in  8*BYTES_PER_BEAT  message bytes; first byte in the MSBs
s_last  in  1  final beat of the message
s_nbytes  in  3  valid bytes on the last beat (1..BYTES_PER_BEAT); ignored on other beats
m_cs  out  1  core chip select
m_we  out  1  core write enable
m_address  out  8  core register address
m_write_data  out  32  core write data
m_read_data  in  32  core read data, combinational from m_address
m_error  in  1  core bus error
digest  out  256  result; word 0x20 in bits [255:224]
digest_valid  out  1  one-cycle pulse when digest is updated
busy  out  1  high from the first accepted beat until DONE or error
error  out  1  sticky; cleared by the next accepted first beat

Behaviour:
- Reset: every output is 0, s_ready=0 for one cycle after release, then 1. The FSM goes to IDLE and all counters clear. Reset mid-operation abandons the hash with no core write.
- Core map: CTRL 0x08 (bit0 init, bit1 next, bit2 mode); STATUS 0x09 (bit0 ready, bit1 digest_valid); block words 0x10-0x1F; digest 0x20-0x27.
- FSM states: IDLE -> FILL -> WRITE_BLK -> START -> POLL -> (FILL | PAD_FILL | READ_DIG) -> DONE -> IDLE.
- FILL: accepts beats into a 16x32 buffer, big-endian byte packing. s_ready=1 only in IDLE/FILL. When 64 bytes are buffered, go to WRITE_BLK.
- WRITE_BLK: 16 consecutive cycles with m_cs=1, m_we=1, address 0x10+i.
- START: one write to CTRL = {MODE_SHA256,next,init}. Init is used for the first block, next for later blocks.
- POLL: m_cs=1, m_we=0, address 0x09 every cycle until STATUS bit0=1. More than POLL_LIMIT reads sets error and returns to IDLE.
- Padding after s_last: append 0x80, zero-fill, then the 64-bit bit length (bytes<<3) big-endian in words 14/15.
  - If bytes mod 64 >= 56 after 0x80 is placed, the length goes into an extra all-pad block.
  - A zero-length message is legal. s_last with s_nbytes=0 is treated as an empty beat.
- READ_DIG: 8 reads at 0x20..0x27, one per cycle, each captured into digest. digest_valid pulses the cycle after the last read.
- Errors: m_error high on any access, or byte-count overflow, sets error, aborts to IDLE and drops the rest of that message. The stream stays ready for a new one.
- Throughput: one beat per cycle in FILL. Core latency is covered by POLL; no fixed latency is assumed.

Decomposition:
- Package sha256_stream_pkg holds the core address constants, CTRL bit positions, the FSM state enum and the padding byte constant 0x80.
- One sub-module, sha256_block_buffer: a 16-word byte-lane packer with pad/length insertion and a word read port indexed by the FSM.

Test Plan:
- Empty message (single beat, s_last, s_nbytes=0) -> one init block; digest e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- "abc" as one 4-byte-lane beat with s_nbytes=3 -> one block; digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- 56-byte "abcdbcdecdefdefg...nopq" -> two CTRL writes (0x5 then 0x6); digest 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- 55-byte vs 64-byte message -> bus monitor counts exactly 1 vs 2 START writes; word 15 of the final block equals 0x1B8 / 0x200.
- Core model holds ready=0 forever, POLL_LIMIT=15 -> error rises after 16 status reads, busy falls, next message hashes correctly.
- reset_n pulsed low during WRITE_BLK -> outputs return to 0 asynchronously; a following "abc" yields the correct digest.
